rvbridge_vip_packetizer: RTL and testbench

RVBRIDGE_VIP_PACKETIZER -- requirements
Module: rvbridge_vip_packetizer

---
 rtl/rvbridge_pkg.sv | 40 ++++
 rtl/rvbridge_sc_fifo.sv | 60 ++++++
 rtl/rvbridge_vip_packetizer.sv | 256 +++++++++++++++++++++++++
 tb/tb_rvbridge_vip_packetizer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvbridge_pkg.sv
// Shared constants, state encoding and control-packet helpers for the VIP packetizer.
package rvbridge_pkg;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;
  localparam logic [3:0] CTRL_INTERLACE = 4'h3;
  localparam int unsigned CTRL_PAYLOAD_SYMS = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_CTRL   = 2'd2
  } pk_state_e;

  // Header beat plus the nine payload nibbles spread over the lanes.
  function automatic int unsigned ctrl_beats(input int unsigned symbols);
    return 1 + (CTRL_PAYLOAD_SYMS + symbols - 1) / symbols;
  endfunction

  // Payload nibble idx: width MSB-first, height MSB-first, interlace code, then padding.
  function automatic logic [3:0] ctrl_symbol(input int unsigned idx,
                                             input logic [15:0] width,
                                             input logic [15:0] height);
    logic [3:0] sym;
    case (idx)
      32'd0:   sym = width[15:12];
      32'd1:   sym = width[11:8];
      32'd2:   sym = width[7:4];
      32'd3:   sym = width[3:0];
      32'd4:   sym = height[15:12];
      32'd5:   sym = height[11:8];
      32'd6:   sym = height[7:4];
      32'd7:   sym = height[3:0];
      32'd8:   sym = CTRL_INTERLACE;
      default: sym = 4'h0;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/rvbridge_sc_fifo.sv
// Single-clock FIFO with a registered show-ahead output stage; the output
// register counts as one of the DEPTH entries.
module rvbridge_sc_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    count;
  logic             wr_ok;
  logic             load;

  assign level_c = count + LW'(rd_valid);
  assign full_c  = (level_c >= LW'(DEPTH));
  assign empty_c = (level_c == '0);
  assign wr_ok   = wr_en & ~full_c;
  assign load    = (count != '0) & (~rd_valid | rd_ready);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  // Pointers, occupancy and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      count <= count + LW'(wr_ok) - LW'(load);
      if (load) begin
        rd_data  <= mem[rptr];
        rd_valid <= 1'b1;
        rptr     <= rptr + AW'(1);
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rvbridge_vip_packetizer.sv
// Raw video (fs/de) to Avalon-ST video packetizer with output FIFO.
// Optional control packets and frame measurement under RVBRIDGE_CTRL_PKT_EN.
module rvbridge_vip_packetizer
  import rvbridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SYMBOLS    = 3,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH*SYMBOLS-1:0] raw_data,
  input  logic                          raw_fs,
  input  logic                          raw_de,
  output logic [DATA_WIDTH*SYMBOLS-1:0] st_data,
  output logic                          st_valid,
  output logic                          st_startofpacket,
  output logic                          st_endofpacket,
  input  logic                          st_ready,
  input  logic                          ovf_clr,
  output logic                          ovf_sticky
);

  localparam int unsigned BW = DATA_WIDTH * SYMBOLS;
  localparam int unsigned FW = BW + 2;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [BW-1:0] s1_data;
  logic          s1_fs;
  logic          s1_de;
  logic          s1_fs_d;
  logic          s1_vld;
  logic          armed;
  logic          fs_rise_c;
  logic          fs_fall_c;
  logic          pixel_c;

  pk_state_e     state;
  pk_state_e     state_n;
  logic [BW-1:0] hold_data;
  logic          hold_sop;
  logic          hold_ld;
  logic [BW-1:0] hold_ld_data;
  logic          hold_ld_sop;
  logic          wr_req;
  logic [BW-1:0] wr_beat;
  logic          wr_sop;
  logic          wr_eop;
  logic          pix_drop;
  logic          ovf_evt;

  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [FW-1:0] fifo_rd;

  logic          ctrl_go_c;
  logic          ctrl_skip_c;
  logic          ctrl_first_c;
  logic          ctrl_last_c;
  logic [BW-1:0] ctrl_beat_c;

  // Input stage; armed stays low until fs has been seen low after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_fs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_fs_d <= 1'b0;
      s1_vld  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      s1_data <= raw_data;
      s1_fs   <= raw_fs;
      s1_de   <= raw_de;
      s1_fs_d <= s1_fs;
      s1_vld  <= 1'b1;
      armed   <= armed | (s1_vld & ~s1_fs);
    end
  end

  assign fs_rise_c = armed & s1_fs & ~s1_fs_d;
  assign fs_fall_c = ~s1_fs & s1_fs_d;
  assign pixel_c   = s1_fs & s1_de;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    hold_ld      = 1'b0;
    hold_ld_data = '0;
    hold_ld_sop  = 1'b0;
    wr_req       = 1'b0;
    wr_beat      = '0;
    wr_sop       = 1'b0;
    wr_eop       = 1'b0;
    pix_drop     = 1'b0;
    ovf_evt      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fs_rise_c) begin
          hold_ld      = 1'b1;
          hold_ld_data = BW'(PKT_TYPE_VIDEO);
          hold_ld_sop  = 1'b1;
          state_n      = ctrl_go_c ? ST_CTRL : ST_ACTIVE;
          ovf_evt      = ctrl_skip_c;
        end
      end
      ST_ACTIVE: begin
        if (fs_fall_c) begin
          wr_req  = 1'b1;
          wr_beat = hold_data;
          wr_sop  = hold_sop;
          wr_eop  = 1'b1;
          state_n = ST_IDLE;
        end else if (pixel_c) begin
          wr_req       = 1'b1;
          wr_beat      = hold_data;
          wr_sop       = hold_sop;
          hold_ld      = 1'b1;
          hold_ld_data = s1_data;
        end
      end
      ST_CTRL: begin
        wr_req   = 1'b1;
        wr_beat  = ctrl_beat_c;
        wr_sop   = ctrl_first_c;
        wr_eop   = ctrl_last_c;
        pix_drop = pixel_c;
        if (ctrl_last_c) state_n = ST_ACTIVE;
      end
      default: state_n = ST_IDLE;
    endcase
    ovf_evt = ovf_evt | pix_drop | (wr_req & fifo_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_sop  <= 1'b0;
    end else if (hold_ld) begin
      hold_data <= hold_ld_data;
      hold_sop  <= hold_ld_sop;
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_sticky <= 1'b0;
    else if (ovf_evt) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end

`ifdef RVBRIDGE_CTRL_PKT_EN
  localparam int unsigned CTRL_BEATS = ctrl_beats(SYMBOLS);

  logic        pix_d;
  logic        run_done;
  logic [15:0] w_cnt;
  logic [15:0] h_cnt;
  logic [15:0] meas_w;
  logic [15:0] meas_h;
  logic        ctrl_valid;
  logic [3:0]  cb;
  logic [LW-1:0] fifo_free_c;

  // Width = first de run length, height = de rising edges, both saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_d      <= 1'b0;
      run_done   <= 1'b0;
      w_cnt      <= '0;
      h_cnt      <= '0;
      meas_w     <= '0;
      meas_h     <= '0;
      ctrl_valid <= 1'b0;
    end else begin
      pix_d <= pixel_c & (state == ST_ACTIVE);
      if (state == ST_IDLE && fs_rise_c) begin
        w_cnt    <= '0;
        h_cnt    <= '0;
        run_done <= 1'b0;
      end else if (state == ST_ACTIVE) begin
        if (fs_fall_c) begin
          meas_w     <= w_cnt;
          meas_h     <= h_cnt;
          ctrl_valid <= 1'b1;
        end
        if (pixel_c && !run_done && w_cnt != 16'hFFFF) w_cnt <= w_cnt + 16'd1;
        if (pixel_c && !pix_d && h_cnt != 16'hFFFF)    h_cnt <= h_cnt + 16'd1;
        if (!pixel_c && pix_d)                          run_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cb <= '0;
    else if (state == ST_CTRL)  cb <= cb + 4'd1;
    else                        cb <= '0;
  end

  assign fifo_free_c  = LW'(FIFO_DEPTH) - fifo_level;
  assign ctrl_skip_c  = fs_rise_c & ctrl_valid & (fifo_free_c < LW'(CTRL_BEATS));
  assign ctrl_go_c    = fs_rise_c & ctrl_valid & ~ctrl_skip_c;
  assign ctrl_first_c = (cb == 4'd0);
  assign ctrl_last_c  = (cb == 4'(CTRL_BEATS - 1));

  always_comb begin
    ctrl_beat_c = '0;
    if (cb == 4'd0) begin
      ctrl_beat_c[3:0] = PKT_TYPE_CTRL;
    end else begin
      for (int unsigned l = 0; l < SYMBOLS; l++) begin
        ctrl_beat_c[l*DATA_WIDTH +: 4] =
          ctrl_symbol((32'(cb) - 32'd1) * SYMBOLS + l, meas_w, meas_h);
      end
    end
  end

  logic unused_fifo;
  assign unused_fifo = fifo_empty;
`else
  assign ctrl_skip_c  = 1'b0;
  assign ctrl_go_c    = 1'b0;
  assign ctrl_first_c = 1'b0;
  assign ctrl_last_c  = 1'b1;
  assign ctrl_beat_c  = '0;

  logic unused_fifo;
  assign unused_fifo = ^{fifo_empty, fifo_level};
`endif

  rvbridge_sc_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_req),
    .wr_data  ({wr_sop, wr_eop, wr_beat}),
    .rd_ready (st_ready),
    .rd_valid (st_valid),
    .rd_data  (fifo_rd),
    .full_c   (fifo_full),
    .empty_c  (fifo_empty),
    .level_c  (fifo_level)
  );

  assign st_data          = fifo_rd[BW-1:0];
  assign st_endofpacket   = fifo_rd[BW];
  assign st_startofpacket = fifo_rd[BW+1];

endmodule

// File: tb/tb_rvbridge_vip_packetizer.sv
// Scoreboard bench for rvbridge_vip_packetizer (default parameters; control-packet
// expectations follow RVBRIDGE_CTRL_PKT_EN).
module tb_rvbridge_vip_packetizer;

  localparam int unsigned BW = 24;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] raw_data;
  logic          raw_fs;
  logic          raw_de;
  logic [BW-1:0] st_data;
  logic          st_valid;
  logic          st_sop;
  logic          st_eop;
  logic          st_ready;
  logic          ovf_clr;
  logic          ovf_sticky;

  int    checks = 0;
  int    failures = 0;
  int    beats_seen = 0;
  int    ready_mode = 0;
  beat_t exp_q[$];
  logic        m_cv;
  logic [15:0] m_w;
  logic [15:0] m_h;
  logic        stall_pend;
  beat_t       stall_beat;

  rvbridge_vip_packetizer #(
    .DATA_WIDTH (8),
    .SYMBOLS    (3),
    .FIFO_DEPTH (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .raw_data         (raw_data),
    .raw_fs           (raw_fs),
    .raw_de           (raw_de),
    .st_data          (st_data),
    .st_valid         (st_valid),
    .st_startofpacket (st_sop),
    .st_endofpacket   (st_eop),
    .st_ready         (st_ready),
    .ovf_clr          (ovf_clr),
    .ovf_sticky       (ovf_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = never ready.
  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       st_ready = ~st_ready;
        2:       st_ready = 1'b0;
        default: st_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  initial begin
    stall_pend = 1'b0;
    stall_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          checks++;
          if (!st_valid || st_data !== stall_beat.data ||
              st_sop !== stall_beat.sop || st_eop !== stall_beat.eop) begin
            failures++;
            $display("FAIL stall_hold: got v=%0b d=0x%06h s=%0b e=%0b expected v=1 d=0x%06h s=%0b e=%0b",
                     st_valid, st_data, st_sop, st_eop, stall_beat.data, stall_beat.sop, stall_beat.eop);
          end
        end
        if (st_valid && st_ready) begin
          beats_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: got d=0x%06h s=%0b e=%0b expected no beat",
                     st_data, st_sop, st_eop);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            if (st_data !== e.data || st_sop !== e.sop || st_eop !== e.eop) begin
              failures++;
              $display("FAIL beat: got d=0x%06h s=%0b e=%0b expected d=0x%06h s=%0b e=%0b",
                       st_data, st_sop, st_eop, e.data, e.sop, e.eop);
            end
          end
        end
        stall_pend = st_valid && !st_ready;
        stall_beat = '{data: st_data, sop: st_sop, eop: st_eop};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Pushes the expected beats (first cap only), then drives the frame.
  task automatic send_frame(input int lines, input int ppl, input int fid, input int cap);
    beat_t lst[$];
    int    npix;
    npix = lines * ppl;
`ifdef RVBRIDGE_CTRL_PKT_EN
    if (m_cv) begin
      logic [3:0]    nib [9];
      logic [BW-1:0] d;
      nib = '{m_w[15:12], m_w[11:8], m_w[7:4], m_w[3:0],
              m_h[15:12], m_h[11:8], m_h[7:4], m_h[3:0], 4'h3};
      lst.push_back('{data: 24'h00000F, sop: 1'b1, eop: 1'b0});
      for (int b = 0; b < 3; b++) begin
        d = '0;
        for (int k = 0; k < 3; k++) d[k*8 +: 4] = nib[b*3 + k];
        lst.push_back('{data: d, sop: 1'b0, eop: (b == 2)});
      end
    end
`endif
    lst.push_back('{data: 24'h000000, sop: 1'b1, eop: (npix == 0)});
    for (int l = 0; l < lines; l++)
      for (int p = 0; p < ppl; p++)
        lst.push_back('{data: {8'(fid), 8'(l), 8'(p + 1)}, sop: 1'b0,
                        eop: (l == lines - 1 && p == ppl - 1)});
    for (int i = 0; i < lst.size() && i < cap; i++) exp_q.push_back(lst[i]);
    m_w  = (lines > 0) ? 16'(ppl) : 16'd0;
    m_h  = 16'(lines);
    m_cv = 1'b1;

    raw_fs = 1'b1;
    repeat (6) step();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        raw_de   = 1'b1;
        raw_data = {8'(fid), 8'(l), 8'(p + 1)};
        step();
      end
      raw_de   = 1'b0;
      raw_data = '0;
      repeat (2) step();
    end
    raw_fs = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int b0;
    rst_n    = 1'b0;
    raw_data = '0;
    raw_fs   = 1'b0;
    raw_de   = 1'b0;
    ovf_clr  = 1'b0;
    m_cv     = 1'b0;
    m_w      = '0;
    m_h      = '0;
    repeat (3) step();
    chk("rst_valid", 32'(st_valid), 32'd0);
    chk("rst_sop",   32'(st_sop),   32'd0);
    chk("rst_eop",   32'(st_eop),   32'd0);
    chk("rst_data",  32'(st_data),  32'd0);
    chk("rst_ovf",   32'(ovf_sticky), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // 2 lines x 4 pixels, always ready: header + 8 pixels.
    ready_mode = 0;
    b0 = beats_seen;
    send_frame(2, 4, 1, 1000);
    drain("t1_drain");
    chk("t1_beat_count", 32'(beats_seen - b0), 32'd9);
    chk("t1_ovf", 32'(ovf_sticky), 32'd0);

    // Frame pulse without pixels.
    send_frame(0, 0, 2, 1000);
    drain("t2_drain");

    // Toggling ready, same frame shape.
    ready_mode = 1;
    send_frame(2, 4, 3, 1000);
    drain("t3_drain");

    // Sink stalled through a 20-pixel frame: 16 beats kept, rest dropped.
    ready_mode = 2;
    repeat (2) step();
    send_frame(1, 20, 4, 16);
    chk("t4_ovf_set", 32'(ovf_sticky), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(ovf_sticky), 32'd0);
    ready_mode = 0;
    drain("t4_drain");
    step();
    chk("t4_ovf_after", 32'(ovf_sticky), 32'd0);

    // Two 4x2 frames; the second one carries the 4-wide, 2-high control packet.
    send_frame(2, 4, 5, 1000);
    drain("t5a_drain");
    send_frame(2, 4, 6, 1000);
    drain("t5b_drain");

    // Reset in the middle of a frame with beats waiting at the output.
    ready_mode = 2;
    raw_fs = 1'b1;
    repeat (6) step();
    for (int p = 0; p < 3; p++) begin
      raw_de   = 1'b1;
      raw_data = {8'h70, 8'h00, 8'(p + 1)};
      step();
    end
    raw_de   = 1'b0;
    raw_data = '0;
    repeat (4) step();
    chk("t6_pre_valid", 32'(st_valid), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_cv = 1'b0;
    chk("t6_rst_valid", 32'(st_valid), 32'd0);
    chk("t6_rst_sop",   32'(st_sop),   32'd0);
    chk("t6_rst_data",  32'(st_data),  32'd0);
    repeat (2) step();
    rst_n      = 1'b1;
    ready_mode = 0;
    for (int p = 0; p < 5; p++) begin
      raw_de   = 1'b1;
      raw_data = {8'h71, 8'h00, 8'(p + 1)};
      step();
      raw_de = 1'b0;
      step();
    end
    raw_fs = 1'b0;
    repeat (4) step();
    chk("t6_no_output", 32'(st_valid), 32'd0);
    send_frame(2, 3, 8, 1000);
    drain("t6_drain");
    repeat (5) step();
    chk("end_idle", 32'(st_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
